t07_mmio_responder: RTL and testbench
=====================================

# t07_mmio_responder

Memory-side responder for the CPU's MMIO request interface. Accepts fetch, load and store requests encoded on `rwi`, raises `busy_o` while it runs one transaction on a req/ack memory bus, then drops `busy_o` to mark completion. Returns read data on `rdata_o` (loads) or `instr_o` (fetches). Sits between the CPU memory handler and the SRAM/peripheral bus fabric.

## Interface
Parameters:
- `TIMEOUT`, default 16: maximum number of cycles in REQ waiting for `mem_ack_i` before the transaction aborts. Legal range is 2 to 255.

Ports:
- `clk`  in  1  system clock; everything is on the rising edge.
- `rst`  in  1  synchronous reset, active-high.
- `rwi`  in  2  request code: 00 idle, 01 write (store), 10 read (load), 11 fetch.
- `addr_i`  in  32  request byte address.
- `wdata_i`  in  32  store data, already formatted and zero-extended by the requester.
- `busy_o`  out  1  high while a transaction is in flight; the falling edge marks completion.
- `rdata_o`  out  32  last load result; held until the next load completes.
- `instr_o`  out  32  last fetch result; held until the next fetch completes.
- `err_o`  out  1  one-cycle pulse on timeout abort.
- `err_sticky_o`  out  1  set on any timeout; cleared only by `rst`.
- `mem_req_o`  out  1  bus request; held high until ack or timeout.
- `mem_we_o`  out  1  1 for write, 0 for read/fetch; stable while `mem_req_o` is high.
- `mem_addr_o`  out  32  word-aligned address, `{addr[31:2],2'b00}`.
- `mem_wdata_o`  out  32  write data.
- `mem_sel_o`  out  4  byte enables; always 4'hF during a request, 0 otherwise.
- `mem_ack_i`  in  1  bus completion; single cycle; read data valid in the same cycle.
- `mem_rdata_i`  in  32  bus read data.

## Operation
- States are IDLE, REQ and DONE.
- **IDLE:**
  - If `rwi != 00`, capture the command, address and write data into internal registers and go to REQ.
  - If `rwi == 00`, stay in IDLE.
- **REQ:**
  - Drive `mem_req_o`=1 and the captured command, address and data onto the bus.
  - Ignore `rwi`, `addr_i` and `wdata_i`. The requester's wait states drive `rwi`=11, and that must not re-trigger.
  - Wait-cycle counter starts at 0 on entry and increments each cycle without ack.
  - On `mem_ack_i`=1:
    - read: `rdata_o` <= `mem_rdata_i`.
    - fetch: `instr_o` <= `mem_rdata_i`.
    - write: no data register changes.
    - Then go to DONE.
  - On counter == `TIMEOUT-1` with no ack, abort:
    - the result register for the captured command (`rdata_o` for read, `instr_o` for fetch) <= 32'hDEADBEEF.
    - `err_o` pulses, `err_sticky_o` <= 1.
    - Go to DONE.
  - If ack and the timeout condition occur in the same cycle, ack wins and there is no error.
- **DONE:**
  - Lasts exactly one cycle with `busy_o`=0 and `mem_req_o`=0.
  - `rwi` is ignored, because the requester is still showing its wait-state code during this cycle.
  - Always return to IDLE.
- `busy_o` is registered: it is 1 exactly when the state is REQ.
- `mem_ack_i` is ignored in IDLE and DONE. `rwi` is ignored outside IDLE.
- Only one transaction is outstanding at a time.

## Timing
- **Reset:** synchronous; on a `clk` edge with `rst`=1, state <= IDLE. All of the following become 0: `busy_o`, `rdata_o`, `instr_o`, `err_o`, `err_sticky_o`, `mem_req_o`, `mem_we_o`, `mem_addr_o`, `mem_wdata_o`, `mem_sel_o`.
- **Reset mid-transaction:** `mem_req_o` drops on that edge and no result register updates.
- **Request capture:** request sampled in IDLE at edge k.
  - `busy_o`=1 and `mem_req_o`=1 from edge k to edge k+1.
  - `busy_o` is high for at least one full cycle.
- **Ack in first REQ cycle (k to k+1):**
  - Result registered at edge k+1.
  - `busy_o`=0 from edge k+1.
  - DONE from k+1 to k+2; IDLE from edge k+2.
  - Earliest next capture at edge k+3.
- **General latency:** N wait cycles before ack gives `busy_o` high for N+1 cycles.
- **Timeout:** `busy_o` high for exactly `TIMEOUT` cycles. `err_o` is high for the single cycle following the abort edge, which coincides with DONE.
- **Result validity:** `rdata_o` and `instr_o` are valid from the cycle `busy_o` falls. They hold until overwritten by a later completion of the same command type.

## Test plan
- **Fetch, immediate ack:** reset; `rwi`=11, `addr_i`=0x0000_1006; ack next cycle with `mem_rdata_i`=0x0050_0093.
  - `mem_addr_o`=0x0000_1004, `mem_we_o`=0, `mem_sel_o`=F.
  - `busy_o` high exactly 1 cycle; `instr_o`=0x0050_0093; `rdata_o` stays 0.
- **Store with 3 wait cycles:** `rwi`=01, `addr_i`=0x2000_0010, `wdata_i`=0x0000_00AB; ack on the 4th REQ cycle.
  - `mem_we_o`=1 and `mem_wdata_o`=0xAB held 4 cycles.
  - `busy_o` high 4 cycles; `rdata_o` and `instr_o` unchanged.
- **Held `rwi` during wait and DONE:** `rwi` stays 11 through REQ and DONE, then changes to 10.
  - Exactly one fetch occurs; the load is captured in the first IDLE cycle.
  - `rdata_o` gets the ack data and `instr_o` keeps the fetch value.
- **Timeout:** `TIMEOUT`=16; load with `mem_ack_i` tied 0.
  - `busy_o` high 16 cycles, then `rdata_o`=0xDEADBEEF.
  - `err_o` pulses one cycle; `err_sticky_o` stays 1.
  - A late ack in IDLE is ignored.
- **Ack on the timeout cycle:** ack asserted in REQ cycle 16 with `mem_rdata_i`=0x1234_5678.
  - `rdata_o`=0x1234_5678; no `err_o`; `err_sticky_o` unchanged.
- **Reset mid-REQ:** assert `rst` in the second REQ cycle.
  - Next cycle all outputs are 0 and state is IDLE; the result registers are not written.

Source files
------------

// File: rtl/t07_mmio_responder.sv
// MMIO responder: runs one fetch/load/store per CPU request on a req/ack
// memory bus, with a wait-cycle timeout that substitutes 32'hDEADBEEF.
module t07_mmio_responder #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  rwi,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic        busy_o,
  output logic [31:0] rdata_o,
  output logic [31:0] instr_o,
  output logic        err_o,
  output logic        err_sticky_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  output logic [3:0]  mem_sel_o,
  input  logic        mem_ack_i,
  input  logic [31:0] mem_rdata_i
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_DONE
  } state_e;

  typedef enum logic [1:0] {
    CMD_NONE  = 2'b00,
    CMD_WRITE = 2'b01,
    CMD_READ  = 2'b10,
    CMD_FETCH = 2'b11
  } cmd_e;

  localparam logic [7:0]  LAST_WAIT  = 8'(TIMEOUT - 1);
  localparam logic [31:0] ABORT_DATA = 32'hDEAD_BEEF;

  state_e      state_q, state_d;
  cmd_e        cmd_q, cmd_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [7:0]  wait_q, wait_d;
  logic [31:0] rdata_q, rdata_d;
  logic [31:0] instr_q, instr_d;
  logic        err_q, err_d;
  logic        sticky_q, sticky_d;

  always_comb begin
    // NOTE: every signal gets its hold value first so no path leaves it unassigned (no latches).
    state_d  = state_q;
    cmd_d    = cmd_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    wait_d   = wait_q;
    rdata_d  = rdata_q;
    instr_d  = instr_q;
    err_d    = 1'b0;
    sticky_d = sticky_q;

    unique case (state_q)
      S_IDLE: begin
        if (rwi != CMD_NONE) begin
          cmd_d   = cmd_e'(rwi);
          addr_d  = addr_i & 32'hFFFF_FFFC;
          wdata_d = wdata_i;
          wait_d  = 8'd0;
          state_d = S_REQ;
        end
      end

      S_REQ: begin
        // Ack is tested first so it wins over a timeout in the same cycle.
        if (mem_ack_i) begin
          if (cmd_q == CMD_READ)  rdata_d = mem_rdata_i;
          if (cmd_q == CMD_FETCH) instr_d = mem_rdata_i;
          state_d = S_DONE;
        end else if (wait_q == LAST_WAIT) begin
          if (cmd_q == CMD_READ)  rdata_d = ABORT_DATA;
          if (cmd_q == CMD_FETCH) instr_d = ABORT_DATA;
          err_d    = 1'b1;
          sticky_d = 1'b1;
          state_d  = S_DONE;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end

      S_DONE:  state_d = S_IDLE;

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
    if (rst) begin
      state_q  <= S_IDLE;
      cmd_q    <= CMD_NONE;
      addr_q   <= '0;
      wdata_q  <= '0;
      wait_q   <= '0;
      rdata_q  <= '0;
      instr_q  <= '0;
      err_q    <= 1'b0;
      sticky_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cmd_q    <= cmd_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      wait_q   <= wait_d;
      rdata_q  <= rdata_d;
      instr_q  <= instr_d;
      err_q    <= err_d;
      sticky_q <= sticky_d;
    end
  end

  assign busy_o       = (state_q == S_REQ);
  assign mem_req_o    = busy_o;
  assign mem_we_o     = busy_o && (cmd_q == CMD_WRITE);
  assign mem_sel_o    = busy_o ? 4'hF : 4'h0;
  assign mem_addr_o   = addr_q;
  assign mem_wdata_o  = wdata_q;
  assign rdata_o      = rdata_q;
  assign instr_o      = instr_q;
  assign err_o        = err_q;
  assign err_sticky_o = sticky_q;

endmodule

// File: tb/tb_t07_mmio_responder.sv
// Self-checking bench for t07_mmio_responder: directed scenarios plus random
// transactions scored against a transaction-level model of the responder.
module tb_t07_mmio_responder;

  localparam int T = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  rwi;
  logic [31:0] addr_i, wdata_i;
  logic        busy_o, err_o, err_sticky_o;
  logic [31:0] rdata_o, instr_o;
  logic        mem_req_o, mem_we_o;
  logic [31:0] mem_addr_o, mem_wdata_o;
  logic [3:0]  mem_sel_o;
  logic        mem_ack_i;
  logic [31:0] mem_rdata_i;

  int total = 0;
  int bad   = 0;

  // Transaction-level model state: what the result registers should hold.
  logic [31:0] exp_rdata, exp_instr;
  logic        exp_sticky;

  t07_mmio_responder #(.TIMEOUT(T)) dut (
    .clk          (clk),
    .rst          (rst),
    .rwi          (rwi),
    .addr_i       (addr_i),
    .wdata_i      (wdata_i),
    .busy_o       (busy_o),
    .rdata_o      (rdata_o),
    .instr_o      (instr_o),
    .err_o        (err_o),
    .err_sticky_o (err_sticky_o),
    .mem_req_o    (mem_req_o),
    .mem_we_o     (mem_we_o),
    .mem_addr_o   (mem_addr_o),
    .mem_wdata_o  (mem_wdata_o),
    .mem_sel_o    (mem_sel_o),
    .mem_ack_i    (mem_ack_i),
    .mem_rdata_i  (mem_rdata_i)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // One transaction: optional idle gap, request in IDLE, requester shows
  // wait-state code 11 with noisy addr/data while busy, memory acks after
  // 'delay' wait cycles (never, if delay >= T).
  task automatic run_txn(input logic [1:0] cmd, input logic [31:0] addr,
                         input logic [31:0] wdata, input int delay,
                         input logic [31:0] bus_data, input int gap);
    int          n;
    logic        to;
    logic [31:0] er, ei;
    for (int g = 0; g < gap; g++) begin
      @(negedge clk);
      rwi = 2'b00;
    end
    @(negedge clk);
    total++;
    if ({busy_o, err_o, mem_req_o} !== 3'b000) begin
      bad++;
      $display("FAIL idle_before: busy/err/req=%b expected 000", {busy_o, err_o, mem_req_o});
    end
    rwi = cmd; addr_i = addr; wdata_i = wdata; mem_ack_i = 1'b0;

    to = (delay >= T);
    er = exp_rdata;
    ei = exp_instr;
    if (cmd == 2'b10) er = to ? 32'hDEAD_BEEF : bus_data;
    if (cmd == 2'b11) ei = to ? 32'hDEAD_BEEF : bus_data;

    n = 0;
    @(negedge clk);
    rwi = 2'b11;
    addr_i = $urandom;
    wdata_i = $urandom;
    while (busy_o === 1'b1 && n < 300) begin
      total++;
      if ({mem_req_o, mem_we_o, mem_sel_o, mem_addr_o, err_o} !==
          {1'b1, cmd == 2'b01, 4'hF, addr & 32'hFFFF_FFFC, 1'b0}) begin
        bad++;
        $display("FAIL bus_req cyc%0d: req=%b we=%b sel=%h addr=%h err=%b expected we=%b addr=%h",
                 n, mem_req_o, mem_we_o, mem_sel_o, mem_addr_o, err_o, cmd == 2'b01,
                 addr & 32'hFFFF_FFFC);
      end
      total++;
      if ((cmd == 2'b01) && (mem_wdata_o !== wdata)) begin
        bad++;
        $display("FAIL bus_wdata cyc%0d: got %h expected %h", n, mem_wdata_o, wdata);
      end
      total++;
      if ({rdata_o, instr_o} !== {exp_rdata, exp_instr}) begin
        bad++;
        $display("FAIL result_hold cyc%0d: rdata=%h instr=%h expected %h %h",
                 n, rdata_o, instr_o, exp_rdata, exp_instr);
      end
      mem_ack_i   = (n == delay);
      mem_rdata_i = (n == delay) ? bus_data : $urandom;
      n++;
      @(negedge clk);
    end
    mem_ack_i = 1'b0;
    mem_rdata_i = $urandom;

    exp_rdata  = er;
    exp_instr  = ei;
    exp_sticky = exp_sticky | to;

    total++;
    if (n != (to ? T : delay + 1)) begin
      bad++;
      $display("FAIL busy_cycles: got %0d expected %0d", n, to ? T : delay + 1);
    end
    total++;
    if ({busy_o, mem_req_o, mem_sel_o, err_o, err_sticky_o, rdata_o, instr_o} !==
        {1'b0, 1'b0, 4'h0, to, exp_sticky, exp_rdata, exp_instr}) begin
      bad++;
      $display("FAIL done_state: busy=%b req=%b sel=%h err=%b sticky=%b rdata=%h instr=%h expected err=%b sticky=%b rdata=%h instr=%h",
               busy_o, mem_req_o, mem_sel_o, err_o, err_sticky_o, rdata_o, instr_o,
               to, exp_sticky, exp_rdata, exp_instr);
    end
  endtask

  task automatic check_all_zero(input string name);
    total++;
    if ({busy_o, err_o, err_sticky_o, mem_req_o, mem_we_o, mem_sel_o,
         rdata_o, instr_o, mem_addr_o, mem_wdata_o} !== '0) begin
      bad++;
      $display("FAIL %s: busy=%b err=%b sticky=%b req=%b we=%b sel=%h rdata=%h instr=%h addr=%h wdata=%h expected all zero",
               name, busy_o, err_o, err_sticky_o, mem_req_o, mem_we_o, mem_sel_o,
               rdata_o, instr_o, mem_addr_o, mem_wdata_o);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; rwi = 2'b11; addr_i = 32'hFFFF_FFFF; wdata_i = 32'hFFFF_FFFF;
    mem_ack_i = 1'b0; mem_rdata_i = '0;
    repeat (3) @(negedge clk);
    check_all_zero("reset_state");
    rwi = 2'b00;
    rst = 1'b0;
    exp_rdata = '0; exp_instr = '0; exp_sticky = 1'b0;
  endtask

  task automatic test_fetch();
    run_txn(2'b11, 32'h0000_1006, 32'h0, 0, 32'h0050_0093, 0);
  endtask

  task automatic test_store_wait();
    run_txn(2'b01, 32'h2000_0010, 32'h0000_00AB, 3, 32'hCAFE_F00D, 1);
  endtask

  task automatic test_back_to_back();
    // rwi stays 11 through REQ and DONE, the load follows in the first IDLE cycle.
    run_txn(2'b11, 32'h0000_2000, 32'h0, 2, 32'h1111_2222, 0);
    run_txn(2'b10, 32'h0000_3003, 32'h0, 1, 32'h3333_4444, 0);
  endtask

  task automatic test_timeout();
    logic [31:0] hold_r;
    run_txn(2'b10, 32'h4000_0008, 32'h0, 1000, 32'h0, 1);
    @(negedge clk);
    rwi = 2'b00;
    hold_r = exp_rdata;
    mem_ack_i = 1'b1;
    mem_rdata_i = 32'h5555_AAAA;
    @(negedge clk);
    mem_ack_i = 1'b0;
    total++;
    if ({busy_o, err_o, err_sticky_o, rdata_o} !== {1'b0, 1'b0, 1'b1, hold_r}) begin
      bad++;
      $display("FAIL late_ack: busy=%b err=%b sticky=%b rdata=%h expected 0 0 1 %h",
               busy_o, err_o, err_sticky_o, rdata_o, hold_r);
    end
  endtask

  task automatic test_ack_on_timeout();
    run_txn(2'b10, 32'h0000_0040, 32'h0, T - 1, 32'h1234_5678, 0);
    run_txn(2'b11, 32'h0000_0044, 32'h0, T, 32'h9999_9999, 0);
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    rwi = 2'b10; addr_i = 32'h0000_0100;
    @(negedge clk);
    rwi = 2'b11;
    @(negedge clk);
    total++;
    if (busy_o !== 1'b1) begin
      bad++;
      $display("FAIL mid_busy: got %b expected 1", busy_o);
    end
    rst = 1'b1;
    mem_ack_i = 1'b1;
    mem_rdata_i = 32'h7777_8888;
    @(negedge clk);
    check_all_zero("reset_mid_req");
    rst = 1'b0; mem_ack_i = 1'b0; rwi = 2'b00;
    exp_rdata = '0; exp_instr = '0; exp_sticky = 1'b0;
    run_txn(2'b10, 32'h0000_0200, 32'h0, 0, 32'hABCD_0123, 0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++) begin
      run_txn(2'($urandom_range(1, 3)), $urandom, $urandom,
              int'($urandom_range(0, T + 3)), $urandom, int'($urandom_range(0, 2)));
    end
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_store_wait();
    test_back_to_back();
    test_timeout();
    test_ack_on_timeout();
    test_reset_mid();
    test_random();
    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
